// File: rtl/led_seq_sched.sv
// LED bank scheduler: round-robin grant of two LED programs, runs the owner's program from a tick prescaler.
// Latency: ack and first frame land on the grant edge; done lands on the final tick. Requesters hold req until ack.
// Optional: LED_SEQ_PREEMPT_EN lets requester 0 cut a running requester-1 program at its next tick.
module led_seq_sched #(
  parameter int WIDTH = 12,
  parameter int DIV_W = 28,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] tick_div,
  input  logic             req0,
  input  logic [WIDTH-1:0] pat0,
  input  logic [1:0]       mode0,
  input  logic [LEN_W-1:0] len0,
  input  logic             req1,
  input  logic [WIDTH-1:0] pat1,
  input  logic [1:0]       mode1,
  input  logic [LEN_W-1:0] len1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic             aborted,
  output logic             busy,
  output logic             owner,
  output logic [LEN_W-1:0] step,
  output logic             tick,
  output logic [WIDTH-1:0] led
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] count, count_nx;
  logic             last_owner, last_owner_nx;
  logic [WIDTH-1:0] pat_q, pat_nx;
  logic [1:0]       mode_q, mode_nx;
  logic [LEN_W-1:0] len_q, len_nx;

  logic             ack0_nx, ack1_nx, done0_nx, done1_nx, aborted_nx, owner_nx, tick_nx;
  logic [LEN_W-1:0] step_nx;
  logic [WIDTH-1:0] led_nx;

  logic [DIV_W-1:0] div_m1;
  logic             fire;
  logic [LEN_W-1:0] step_inc;
  logic [LEN_W-1:0] last_step;
  logic             do_load;
  logic             load_sel;

  // tick_div of 0 behaves as 1, so the terminal count is never negative
  assign div_m1    = (tick_div == '0) ? '0 : tick_div - DIV_W'(1);
  assign fire      = (count >= div_m1);
  assign step_inc  = step + LEN_W'(1);
  assign last_step = len_q - LEN_W'(1);
  assign busy      = (state == RUN);

  always_comb begin
    state_nx      = state;
    count_nx      = count;
    last_owner_nx = last_owner;
    pat_nx        = pat_q;
    mode_nx       = mode_q;
    len_nx        = len_q;
    ack0_nx       = 1'b0;
    ack1_nx       = 1'b0;
    done0_nx      = 1'b0;
    done1_nx      = 1'b0;
    aborted_nx    = 1'b0;
    tick_nx       = 1'b0;
    owner_nx      = owner;
    step_nx       = step;
    led_nx        = led;
    do_load       = 1'b0;
    load_sel      = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          do_load  = 1'b1;
          load_sel = (req0 && req1) ? ~last_owner : req1;
        end
      end
      RUN: begin
        if (enable) begin
          if (fire) begin
            tick_nx  = 1'b1;
            count_nx = '0;
`ifdef LED_SEQ_PREEMPT_EN
            if (owner && req0) begin
              done1_nx   = 1'b1;
              aborted_nx = 1'b1;
              do_load    = 1'b1;
              load_sel   = 1'b0;
            end else
`endif
            if ((len_q != '0) && (step == last_step)) begin
              done0_nx = ~owner;
              done1_nx = owner;
              led_nx   = '0;
              step_nx  = '0;
              state_nx = IDLE;
            end else begin
              step_nx = step_inc;
              case (mode_q)
                2'd0:    led_nx = {led[WIDTH-2:0], led[WIDTH-1]};
                2'd1:    led_nx = {led[0], led[WIDTH-1:1]};
                2'd2:    led_nx = step_inc[0] ? ~pat_q : pat_q;
                default: led_nx = led;
              endcase
            end
          end else begin
            count_nx = count + DIV_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // Grant path shared by the IDLE arbiter and preemption
    if (do_load) begin
      ack0_nx       = ~load_sel;
      ack1_nx       = load_sel;
      pat_nx        = load_sel ? pat1 : pat0;
      mode_nx       = load_sel ? mode1 : mode0;
      len_nx        = load_sel ? len1 : len0;
      led_nx        = load_sel ? pat1 : pat0;
      owner_nx      = load_sel;
      last_owner_nx = load_sel;
      step_nx       = '0;
      count_nx      = '0;
      state_nx      = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      last_owner <= 1'b1;
      pat_q      <= '0;
      mode_q     <= '0;
      len_q      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      aborted    <= 1'b0;
      tick       <= 1'b0;
      owner      <= 1'b0;
      step       <= '0;
      led        <= '0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      last_owner <= last_owner_nx;
      pat_q      <= pat_nx;
      mode_q     <= mode_nx;
      len_q      <= len_nx;
      ack0       <= ack0_nx;
      ack1       <= ack1_nx;
      done0      <= done0_nx;
      done1      <= done1_nx;
      aborted    <= aborted_nx;
      tick       <= tick_nx;
      owner      <= owner_nx;
      step       <= step_nx;
      led        <= led_nx;
    end
  end

endmodule
